// File: rtl/or16b_sched_pkg.sv
// Shared types and defaults for the or16b frame scheduler.
package or16b_sched_pkg;
    typedef enum logic [1:0] {
        PH_CHG   = 2'd0,
        PH_EVAL  = 2'd1,
        PH_HOLD  = 2'd2,
        PH_RECOV = 2'd3
    } phase_t;

    localparam int NREQ      = 2;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/or16b_sched_rr_arb2.sv
// Two-way round-robin arbiter; grants only while en is high.
import or16b_sched_pkg::*;

module rr_arb2 (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt
);
    // last = id of the most recently granted port; reset to 1 so port 0 wins the first tie
    logic last;

    always_comb begin
        gnt = '0;
        if (en) begin
            if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
            else              gnt = req;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)    last <= 1'b1;
        else if (|gnt) last <= gnt[1];
    end
endmodule

// File: rtl/or16b_sched.sv
// Four-phase frame scheduler for the shared adiabatic OR datapath.
// Define OR16B_SCHED_IDLE_GATE_EN to suppress phase enables on idle frames.
import or16b_sched_pkg::*;

module or16b_sched #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic [NREQ-1:0]  rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] dp_a,
    output logic [WIDTH-1:0] dp_b,
    input  logic [WIDTH-1:0] dp_out,
    output logic             clkpos,
    output logic             clkpos2,
    output logic             clkneg,
    output logic             clkneg2,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    phase_t          ph, ph_nxt;
    logic [1:0]      ph_inc;
    logic [NREQ-1:0] gnt;
    logic            acc, owner, run_nxt;

    assign ph_inc = ph + 2'd1;
    assign ph_nxt = phase_t'(ph_inc);
    assign acc    = |gnt;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rst_n && ph == PH_RECOV),
        .req   (req_valid),
        .gnt   (gnt)
    );

    assign req_ready = gnt;

    // Enables are registered one cycle ahead so they line up with ph.
`ifdef OR16B_SCHED_IDLE_GATE_EN
    assign run_nxt = (ph == PH_RECOV) ? acc : busy;
`else
    assign run_nxt = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ph        <= PH_CHG;
            clkpos    <= 1'b0;
            clkpos2   <= 1'b0;
            clkneg    <= 1'b0;
            clkneg2   <= 1'b0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            dp_a      <= '0;
            dp_b      <= '0;
            busy      <= 1'b0;
            owner     <= 1'b0;
            op_count  <= '0;
        end else begin
            ph        <= ph_nxt;
            clkpos    <= run_nxt && ph_nxt == PH_CHG;
            clkpos2   <= run_nxt && ph_nxt == PH_EVAL;
            clkneg    <= run_nxt && ph_nxt == PH_HOLD;
            clkneg2   <= run_nxt && ph_nxt == PH_RECOV;
            rsp_valid <= '0;
            if (ph == PH_RECOV) begin
                busy <= acc;
                if (acc) begin
                    dp_a  <= gnt[1] ? req_a1 : req_a0;
                    dp_b  <= gnt[1] ? req_b1 : req_b0;
                    owner <= gnt[1];
                end
            end
            // Sample at the end of the hold phase; response shows in the recover phase.
            if (ph == PH_HOLD && busy) begin
                rsp_valid[owner] <= 1'b1;
                rsp_data         <= dp_out;
                if (op_count != {CNT_W{1'b1}})
                    op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end
endmodule

// File: doc/or16b_sched.md
# or16b_sched

Frame-based scheduler for the shared 16-bit adiabatic bitwise-OR datapath. It generates the four-phase power-clock enables (`clkpos`, `clkpos2`, `clkneg`, `clkneg2`) from one digital clock. Two requesters share the datapath through a round-robin arbiter with one operation in flight per 4-cycle frame. It sits between the control logic and the `or16b` array and returns each result to the port that issued it.

## Interface
- `WIDTH`, 16, operand/result width
- `CNT_W`, 16, width of the completed-operation counter
- `clk`  input  1  single system clock
- `rst_n`  input  1  synchronous, active-low reset
- `req_valid`  input  2  per-port request valid
- `req_ready`  output  2  per-port accept; at most one bit high
- `req_a0`, `req_b0`  input  WIDTH  port 0 operands
- `req_a1`, `req_b1`  input  WIDTH  port 1 operands
- `rsp_valid`  output  2  one-cycle result strobe per port; no backpressure
- `rsp_data`  output  WIDTH  result, meaningful only while a `rsp_valid` bit is high
- `dp_a`, `dp_b`  output  WIDTH  registered operands to the datapath
- `dp_out`  input  WIDTH  datapath result
- `clkpos`, `clkpos2`, `clkneg`, `clkneg2`  output  1  one-hot phase enables
- `busy`  output  1  an operation is in flight in the current frame
- `op_count`  output  CNT_W  completed operations, saturating

## Operation
- Phase counter `ph[1:0]` increments every cycle and wraps 3→0.
- Phase enables: `ph`=0 `clkpos` (charge), 1 `clkpos2` (evaluate), 2 `clkneg` (hold), 3 `clkneg2` (recover). The enables are registered and exactly one-hot when active.
- Accept happens only in `ph`==3 cycles. `req_ready` is 0 in all other phases, whatever `req_valid` is.
- Arbitration in a `ph`==3 cycle:
  - If one port is valid, grant that port.
  - If both ports are valid, grant the port other than the last-granted port.
  - The last-grant pointer resets so that port 0 wins the first tie.
- On accept, the granted operands are registered into `dp_a`/`dp_b` at the next edge (`ph`→0). The owner id is recorded and `busy`=1 for that frame.
- With no accept, `dp_a`/`dp_b` hold their previous values and `busy`=0.
- `dp_out` is sampled at the end of the `ph`==2 cycle of a busy frame.
- In the following `ph`==3 cycle, the owner's `rsp_valid` bit is 1 and `rsp_data` carries the sample.
- `op_count` increments on each `rsp_valid` and saturates at all-ones.
- A response and a new accept may occur in the same `ph`==3 cycle, giving back-to-back frames.

## Timing
- Reset values: `ph`=0, all phase enables 0, `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `dp_a`=`dp_b`=0, `busy`=0, `op_count`=0, pointer favours port 0.
- Phase enables are 0 in the first cycle after reset release. The first `ph`==0 enable asserts on the first frame after release.
- Latency: accept in cycle N (`ph`==3) → `rsp_valid` in cycle N+4.
- Throughput: one operation per 4 cycles.
- Reset asserted mid-frame:
  - The in-flight operation is dropped and no response is issued.
  - `op_count` is cleared.
  - Requests pending at reset are not accepted until the first `ph`==3 cycle after release.
- A request dropped before its `ph`==3 cycle is never accepted, with no side effect.
- Requester operands must be stable only in the accepting cycle.

## Configuration
- `OR16B_SCHED_IDLE_GATE_EN` defined: phase enables stay 0 during frames with `busy`=0, so no adiabatic charge is spent on idle frames.
- `OR16B_SCHED_IDLE_GATE_EN` undefined: phase enables cycle every frame regardless of `busy`.
- Accept, response timing and latency are identical in both builds.

## Structure
- Package `or16b_sched_pkg` holds:
  - phase enum `PH_CHG`, `PH_EVAL`, `PH_HOLD`, `PH_RECOV`
  - `NREQ`=2
  - the default `WIDTH` and `CNT_W` constants
- Sub-module `rr_arb2`: 2-way round-robin arbiter with an `en` input (driven by `ph`==3), a request vector, a one-hot grant and an internal last-grant pointer.

## Test plan
- Single request: port 0 a=0x00F0, b=0x0F00, valid from reset release → accepted at the first `ph`==3; `rsp_valid`=2'b01, `rsp_data`=0x0FF0 four cycles later; `op_count`=1.
- Tie: both ports valid continuously with different operands → grants alternate 0,1,0,1 on consecutive frames; each response is routed to the correct port bit with the correct value.
- Phase check (ungated build): for 12 cycles after reset, enables follow the `clkpos`, `clkpos2`, `clkneg`, `clkneg2` order, exactly one-hot. Gated build with no requests → all enables stay 0 and `busy`=0.
- Reset mid-frame: assert `rst_n`=0 at `ph`==1 of a busy frame → no `rsp_valid` ever for that operation; all outputs return to reset values.
- Saturation: preload via 65535 operations (or force `CNT_W`=4 and run 16 operations) → `op_count` holds at all-ones.
- Same-cycle event: `rsp_valid` and a new `req_ready` in one `ph`==3 cycle → both complete correctly and the next response follows 4 cycles later.
